// File: rtl/bcd_updown_counter_display.sv
// N-digit BCD up/down counter with three debounced buttons (up, down, clear)
// and a time-multiplexed active-low 7-segment scan driver with leading-zero blanking.
module bcd_updown_counter_display #(
    parameter int DIGITS             = 8,
    parameter int DEBOUNCE_CYCLES    = 100_000,
    parameter int REFRESH_CYCLES     = 100_000,
    parameter int LEADING_ZERO_BLANK = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  btn_up,
    input  logic                  btn_down,
    input  logic                  btn_clear,
    output logic [4*DIGITS-1:0]   count_bcd,
    output logic                  overflow,
    output logic                  underflow,
    output logic [6:0]            seg,
    output logic [DIGITS-1:0]     an
);

    localparam int TW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int RW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam int B_UP    = 0;
    localparam int B_DOWN  = 1;
    localparam int B_CLEAR = 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRESS,
        S_LOCK1,
        S_HELD,
        S_RELEASE,
        S_LOCK0
    } db_state_t;

    logic [2:0] btn_raw;
    logic [2:0] sync1;
    logic [2:0] sync2;
    logic [2:0] press;

    assign btn_raw = {btn_clear, btn_down, btn_up};

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of its neighbours, which the 2-FF chain relies on.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
        end
    end

    for (genvar b = 0; b < 3; b++) begin : g_db
        db_state_t       state;
        logic [TW-1:0]   timer;
        logic            pulse;

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                state <= S_IDLE;
                timer <= '0;
                pulse <= 1'b0;
            end else begin
                pulse <= 1'b0;
                case (state)
                    S_IDLE: begin
                        if (sync2[b]) begin
                            state <= S_PRESS;
                            pulse <= 1'b1;
                        end
                    end
                    S_PRESS: begin
                        timer <= '0;
                        state <= S_LOCK1;
                    end
                    S_LOCK1: begin
                        if (timer == TW'(DEBOUNCE_CYCLES - 1)) state <= S_HELD;
                        else timer <= timer + 1'b1;
                    end
                    S_HELD: begin
                        if (!sync2[b]) state <= S_RELEASE;
                    end
                    S_RELEASE: begin
                        timer <= '0;
                        state <= S_LOCK0;
                    end
                    S_LOCK0: begin
                        if (timer == TW'(DEBOUNCE_CYCLES - 1)) state <= S_IDLE;
                        else timer <= timer + 1'b1;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end

        assign press[b] = pulse;
    end

    // Ripple carry/borrow; the carry/borrow left over after the top digit is the wrap flag.
    logic [4*DIGITS-1:0] count_inc;
    logic [4*DIGITS-1:0] count_dec;
    logic                carry;
    logic                borrow;

    // NOTE: every always_comb output gets a default before the loop, so no
    // path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        count_inc = count_bcd;
        count_dec = count_bcd;
        carry     = 1'b1;
        borrow    = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (carry) begin
                if (count_bcd[4*i +: 4] == 4'd9) begin
                    count_inc[4*i +: 4] = 4'd0;
                end else begin
                    count_inc[4*i +: 4] = count_bcd[4*i +: 4] + 4'd1;
                    carry = 1'b0;
                end
            end
            if (borrow) begin
                if (count_bcd[4*i +: 4] == 4'd0) begin
                    count_dec[4*i +: 4] = 4'd9;
                end else begin
                    count_dec[4*i +: 4] = count_bcd[4*i +: 4] - 4'd1;
                    borrow = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_bcd <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
            if (press[B_CLEAR]) begin
                count_bcd <= '0;
            end else if (press[B_UP] && !press[B_DOWN]) begin
                count_bcd <= count_inc;
                overflow  <= carry;
            end else if (press[B_DOWN] && !press[B_UP]) begin
                count_bcd <= count_dec;
                underflow <= borrow;
            end
        end
    end

    logic [RW-1:0] tick_cnt;
    logic [IW-1:0] scan_idx;
    logic          tick;

    assign tick = (tick_cnt == RW'(REFRESH_CYCLES - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tick_cnt <= '0;
            scan_idx <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
            scan_idx <= (scan_idx == IW'(DIGITS - 1)) ? '0 : scan_idx + 1'b1;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    logic [3:0] digit_sel;
    logic       blank;
    logic       zero_above;

    always_comb begin
        digit_sel  = 4'd0;
        an         = '1;
        blank      = 1'b0;
        zero_above = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (scan_idx == IW'(i)) begin
                an[i]     = 1'b0;
                digit_sel = count_bcd[4*i +: 4];
            end
        end
        // Walk down from the top digit; a digit blanks only if it and all above are zero.
        for (int i = DIGITS - 1; i > 0; i--) begin
            zero_above = zero_above && (count_bcd[4*i +: 4] == 4'd0);
            if (LEADING_ZERO_BLANK != 0 && zero_above && scan_idx == IW'(i)) blank = 1'b1;
        end
        case (digit_sel)
            4'd0:    seg = 7'b0000001;
            4'd1:    seg = 7'b1001111;
            4'd2:    seg = 7'b0010010;
            4'd3:    seg = 7'b0000110;
            4'd4:    seg = 7'b1001100;
            4'd5:    seg = 7'b0100100;
            4'd6:    seg = 7'b0100000;
            4'd7:    seg = 7'b0001111;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0000100;
            default: seg = 7'b1111111;
        endcase
        if (blank) seg = 7'b1111111;
    end

endmodule

// File: tb/tb_bcd_updown_counter_display.sv
// Randomised bench for bcd_updown_counter_display (3 digits, short debounce/refresh)
// checked against an integer-arithmetic model of the counter and display.
module tb_bcd_updown_counter_display;

    localparam int DIGITS = 3;
    localparam int DEB    = 4;
    localparam int REF    = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        btn_up = 1'b0;
    logic        btn_down = 1'b0;
    logic        btn_clear = 1'b0;
    logic [11:0] count_bcd;
    logic        overflow;
    logic        underflow;
    logic [6:0]  seg;
    logic [2:0]  an;

    int checks = 0;
    int failures = 0;
    int model_val = 0;
    int edges = 0;
    int count_changes = 0;

    bcd_updown_counter_display #(
        .DIGITS(DIGITS),
        .DEBOUNCE_CYCLES(DEB),
        .REFRESH_CYCLES(REF),
        .LEADING_ZERO_BLANK(1)
    ) dut (
        .clk(clk),
        .reset(reset),
        .btn_up(btn_up),
        .btn_down(btn_down),
        .btn_clear(btn_clear),
        .count_bcd(count_bcd),
        .overflow(overflow),
        .underflow(underflow),
        .seg(seg),
        .an(an)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge reset) begin
        if (!reset) edges <= 0;
        else edges <= edges + 1;
    end

    always @(count_bcd) count_changes <= count_changes + 1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

    function automatic logic [11:0] to_bcd(input int v);
        return {4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    function automatic logic [6:0] seg_model(input int v, input int idx);
        int p;
        p = (idx == 0) ? 1 : (idx == 1) ? 10 : 100;
        if (idx > 0 && v < p) return 7'b1111111;
        case ((v / p) % 10)
            0: return 7'b0000001;
            1: return 7'b1001111;
            2: return 7'b0010010;
            3: return 7'b0000110;
            4: return 7'b1001100;
            5: return 7'b0100100;
            6: return 7'b0100000;
            7: return 7'b0001111;
            8: return 7'b0000000;
            default: return 7'b0000100;
        endcase
    endfunction

    task automatic model_press(input logic u, input logic d, input logic c,
                               output logic exp_ov, output logic exp_un);
        exp_ov = 1'b0;
        exp_un = 1'b0;
        if (c) begin
            model_val = 0;
        end else if (u && !d) begin
            exp_ov = (model_val == 999);
            model_val = (model_val + 1) % 1000;
        end else if (d && !u) begin
            exp_un = (model_val == 0);
            model_val = (model_val + 999) % 1000;
        end
    endtask

    // Clean press: buttons rise at a negedge before E0; samples taken #1 after E2, E3, E4.
    task automatic drive_press(input logic u, input logic d, input logic c, input int hold,
                               output logic [11:0] cnt_e2, output logic [11:0] cnt_e3,
                               output logic ov_e3, output logic un_e3,
                               output logic ov_e4, output logic un_e4);
        @(negedge clk);
        btn_up = u;
        btn_down = d;
        btn_clear = c;
        repeat (3) @(posedge clk);
        #1 cnt_e2 = count_bcd;
        @(posedge clk);
        #1;
        cnt_e3 = count_bcd;
        ov_e3 = overflow;
        un_e3 = underflow;
        @(posedge clk);
        #1;
        ov_e4 = overflow;
        un_e4 = underflow;
        repeat (hold) @(negedge clk);
        btn_up = 1'b0;
        btn_down = 1'b0;
        btn_clear = 1'b0;
        repeat (16) @(negedge clk);
    endtask

    task automatic test_reset();
        int idx;
        repeat (3) @(negedge clk);
        checks++;
        if (count_bcd !== 12'h000 || overflow !== 1'b0 || underflow !== 1'b0) begin
            failures++;
            $display("FAIL reset_count: count=%h ov=%b un=%b want 000 0 0", count_bcd, overflow, underflow);
        end
        checks++;
        if (an !== 3'b110 || seg !== 7'b0000001) begin
            failures++;
            $display("FAIL reset_display: an=%b seg=%b want 110 0000001", an, seg);
        end
        reset = 1'b1;
        for (int k = 0; k <= 12; k++) begin
            if (k > 0) @(negedge clk);
            idx = (k / 2) % 3;
            checks++;
            if (an !== ~(3'b001 << idx) || seg !== seg_model(0, idx)) begin
                failures++;
                $display("FAIL reset_scan k=%0d: an=%b seg=%b want an=%b seg=%b",
                         k, an, seg, ~(3'b001 << idx), seg_model(0, idx));
            end
        end
    endtask

    task automatic test_single_up();
        logic [11:0] e2, e3;
        logic ov3, un3, ov4, un4;
        int c0;
        c0 = count_changes;
        drive_press(1'b1, 1'b0, 1'b0, 20, e2, e3, ov3, un3, ov4, un4);
        checks++;
        if (e2 !== 12'h000 || e3 !== 12'h001) begin
            failures++;
            $display("FAIL single_up_latency: e2=%h e3=%h want 000 001", e2, e3);
        end
        checks++;
        if (ov3 !== 1'b0 || un3 !== 1'b0) begin
            failures++;
            $display("FAIL single_up_pulse: ov=%b un=%b want 0 0", ov3, un3);
        end
        checks++;
        if (count_bcd !== 12'h001 || count_changes - c0 != 1) begin
            failures++;
            $display("FAIL single_up_once: count=%h changes=%0d want 001 1", count_bcd, count_changes - c0);
        end
        model_val = 1;
    endtask

    task automatic test_bounce();
        int c0;
        c0 = count_changes;
        @(negedge clk);
        btn_up = 1'b1; #2 btn_up = 1'b0; #2 btn_up = 1'b1; #2 btn_up = 1'b0; #2 btn_up = 1'b1;
        repeat (20) @(negedge clk);
        btn_up = 1'b0; #2 btn_up = 1'b1; #2 btn_up = 1'b0; #2 btn_up = 1'b1; #2 btn_up = 1'b0;
        repeat (20) @(negedge clk);
        checks++;
        if (count_bcd !== 12'h002 || count_changes - c0 != 1) begin
            failures++;
            $display("FAIL bounce_once: count=%h changes=%0d want 002 1", count_bcd, count_changes - c0);
        end
        model_val = 2;
    endtask

    // mode 0: up presses only; mode 1: random mix of buttons plus display checks.
    task automatic test_press_sequence(input int n, input int mode);
        logic [11:0] e2, e3, old_bcd;
        logic ov3, un3, ov4, un4, exp_ov, exp_un;
        logic u, d, c;
        int r, hold, idx;
        for (int p = 0; p < n; p++) begin
            u = 1'b1; d = 1'b0; c = 1'b0;
            if (mode == 1) begin
                r = $urandom_range(0, 9);
                u = (r <= 3) || (r == 8);
                d = (r >= 4 && r <= 6) || (r == 8);
                c = (r == 7);
            end
            hold = $urandom_range(0, 6);
            old_bcd = to_bcd(model_val);
            model_press(u, d, c, exp_ov, exp_un);
            drive_press(u, d, c, hold, e2, e3, ov3, un3, ov4, un4);
            checks++;
            if (e2 !== old_bcd || e3 !== to_bcd(model_val)) begin
                failures++;
                $display("FAIL seq_count p=%0d btn=%b%b%b: e2=%h e3=%h want %h %h",
                         p, c, d, u, e2, e3, old_bcd, to_bcd(model_val));
            end
            checks++;
            if (ov3 !== exp_ov || un3 !== exp_un || ov4 !== 1'b0 || un4 !== 1'b0) begin
                failures++;
                $display("FAIL seq_wrap p=%0d: ov=%b%b un=%b%b want ov=%b0 un=%b0",
                         p, ov3, ov4, un3, un4, exp_ov, exp_un);
            end
            checks++;
            if (count_bcd !== to_bcd(model_val)) begin
                failures++;
                $display("FAIL seq_hold p=%0d: count=%h want %h", p, count_bcd, to_bcd(model_val));
            end
            if (mode == 1) begin
                for (int k = 0; k < 6; k++) begin
                    @(negedge clk);
                    idx = (edges / 2) % 3;
                    checks++;
                    if (an !== ~(3'b001 << idx) || seg !== seg_model(model_val, idx)) begin
                        failures++;
                        $display("FAIL seq_display val=%0d: an=%b seg=%b want an=%b seg=%b",
                                 model_val, an, seg, ~(3'b001 << idx), seg_model(model_val, idx));
                    end
                end
            end
        end
    endtask

    task automatic test_ripple();
        test_press_sequence(98, 0);
        checks++;
        if (count_bcd !== 12'h100) begin
            failures++;
            $display("FAIL ripple_100: count=%h want 100", count_bcd);
        end
    endtask

    task automatic test_wrap();
        logic [2:0]  btn_tab [4] = '{3'b100, 3'b010, 3'b001, 3'b010};
        logic [11:0] exp_tab [4] = '{12'h000, 12'h999, 12'h000, 12'h999};
        logic        ov_tab  [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        logic        un_tab  [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic [11:0] e2, e3;
        logic ov3, un3, ov4, un4;
        for (int s = 0; s < 4; s++) begin
            drive_press(btn_tab[s][0], btn_tab[s][1], btn_tab[s][2], 3, e2, e3, ov3, un3, ov4, un4);
            checks++;
            if (e3 !== exp_tab[s] || ov3 !== ov_tab[s] || un3 !== un_tab[s] || ov4 !== 1'b0 || un4 !== 1'b0) begin
                failures++;
                $display("FAIL wrap step=%0d: count=%h ov=%b%b un=%b%b want %h ov=%b0 un=%b0",
                         s, e3, ov3, ov4, un3, un4, exp_tab[s], ov_tab[s], un_tab[s]);
            end
        end
        model_val = 999;
    endtask

    task automatic test_same_cycle();
        logic [11:0] e2, e3;
        logic ov3, un3, ov4, un4;
        drive_press(1'b0, 1'b0, 1'b1, 2, e2, e3, ov3, un3, ov4, un4);
        model_val = 0;
        checks++;
        if (e3 !== 12'h000) begin
            failures++;
            $display("FAIL same_pre_clear: count=%h want 000", e3);
        end
        test_press_sequence(42, 0);
        drive_press(1'b1, 1'b1, 1'b0, 4, e2, e3, ov3, un3, ov4, un4);
        checks++;
        if (e3 !== 12'h042 || count_bcd !== 12'h042 || ov3 !== 1'b0 || un3 !== 1'b0) begin
            failures++;
            $display("FAIL same_up_down: e3=%h final=%h ov=%b un=%b want 042 042 0 0", e3, count_bcd, ov3, un3);
        end
        drive_press(1'b1, 1'b0, 1'b1, 4, e2, e3, ov3, un3, ov4, un4);
        checks++;
        if (e3 !== 12'h000 || count_bcd !== 12'h000 || ov3 !== 1'b0 || un3 !== 1'b0) begin
            failures++;
            $display("FAIL same_clear_up: e3=%h final=%h ov=%b un=%b want 000 000 0 0", e3, count_bcd, ov3, un3);
        end
        model_val = 0;
    endtask

    task automatic test_reset_mid_lock();
        logic [11:0] e2, e3;
        logic ov3, un3, ov4, un4;
        test_press_sequence(56, 0);
        @(negedge clk);
        btn_up = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (count_bcd !== 12'h057) begin
            failures++;
            $display("FAIL midlock_pre: count=%h want 057", count_bcd);
        end
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        checks++;
        if (count_bcd !== 12'h000 || an !== 3'b110 || seg !== 7'b0000001 || overflow !== 1'b0) begin
            failures++;
            $display("FAIL midlock_async: count=%h an=%b seg=%b ov=%b want 000 110 0000001 0",
                     count_bcd, an, seg, overflow);
        end
        btn_up = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        model_val = 0;
        drive_press(1'b1, 1'b0, 1'b0, 4, e2, e3, ov3, un3, ov4, un4);
        checks++;
        if (e2 !== 12'h000 || e3 !== 12'h001 || count_bcd !== 12'h001) begin
            failures++;
            $display("FAIL midlock_after: e2=%h e3=%h final=%h want 000 001 001", e2, e3, count_bcd);
        end
        model_val = 1;
    endtask

    initial begin
        test_reset();
        test_single_up();
        test_bounce();
        test_ripple();
        test_wrap();
        test_press_sequence(40, 1);
        test_same_cycle();
        test_reset_mid_lock();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
